// File: rtl/ad7643_serial_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_pkg                                                              |
// | Shared AD7643 readout constants and FSM state encoding.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adc_pkg;

  localparam int AD7643_NBITS        = 18;
  localparam int AD7643_DIV          = 2;
  localparam int AD7643_CNV_LOW      = 3;
  localparam int AD7643_BUSY_TIMEOUT = 255;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t CNV     = 3'd1;
  localparam state_t WAIT_HI = 3'd2;
  localparam state_t WAIT_LO = 3'd3;
  localparam state_t SHIFT   = 3'd4;
  localparam state_t DONE    = 3'd5;
  localparam state_t ERR     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/ad7643_serial_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ad7643_serial_reader_if                                              |
// | Control, ADC pin and result signals of one AD7643 readout channel.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ad7643_serial_reader_if #(
  parameter int NBITS = adc_pkg::AD7643_NBITS
);
  logic             start;
  logic             cont;
  logic             adcs;
  logic             adcnvst;
  logic             adsclk;
  logic             adbusy;
  logic             adsdout;
  logic [NBITS-1:0] data;
  logic             dvalid;
  logic             timeout;
  logic             active;

  modport master (
    input  start, cont, adbusy, adsdout,
    output adcs, adcnvst, adsclk, data, dvalid, timeout, active
  );

  modport slave (
    output start, cont, adbusy, adsdout,
    input  adcs, adcnvst, adsclk, data, dvalid, timeout, active
  );
endinterface
`default_nettype wire

// File: rtl/ad7643_serial_reader_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2                                                                |
// | Generic two-flop synchroniser, asynchronous active-low reset.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/ad7643_serial_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ad7643_serial_reader                                                 |
// | CNVST/BUSY/SCLK sequencer and MSB-first shift-in for one AD7643.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ad7643_serial_reader
  import adc_pkg::*;
#(
  parameter int NBITS        = AD7643_NBITS,
  parameter int DIV          = AD7643_DIV,
  parameter int CNV_LOW      = AD7643_CNV_LOW,
  parameter int BUSY_TIMEOUT = AD7643_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ad7643_serial_reader_if.master bus
);
  localparam int c_CW = 16;
  localparam int c_IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNV_LOAD = c_CW'(CNV_LOW - 1);
  localparam logic [c_CW-1:0] c_TMO_LOAD = c_CW'(BUSY_TIMEOUT);
  localparam logic [c_CW-1:0] c_PH_LOAD  = c_CW'(DIV - 1);
  localparam logic [c_IW-1:0] c_IDX_TOP  = c_IW'(NBITS - 1);
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [c_IW-1:0]   r_idx;
  logic [NBITS-1:0]  r_sr;
  logic [NBITS-1:0]  r_data;
  logic              r_dvalid;
  logic              r_timeout;
  logic              r_cs;
  logic              r_cnvst;
  logic              r_sclk;
  logic              w_busy_s;
  logic              w_cnt_zero;

  sync2 #(.WIDTH(1)) u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.adbusy),
    .q     (w_busy_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sr      <= '0;
      r_data    <= '0;
      r_dvalid  <= 1'b0;
      r_timeout <= 1'b0;
      r_cs      <= 1'b1;
      r_cnvst   <= 1'b1;
      r_sclk    <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= CNV;
            r_cs      <= 1'b0;
            r_cnvst   <= 1'b0;
            r_cnt     <= c_CNV_LOAD;
            r_timeout <= 1'b0;
          end
        end
        CNV: begin
          if (w_cnt_zero) begin
            r_cnvst <= 1'b1;
            r_cnt   <= c_TMO_LOAD;
            r_state <= WAIT_HI;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (w_busy_s) begin
            r_cnt   <= c_TMO_LOAD;
            r_state <= WAIT_LO;
          end else if (w_cnt_zero) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (!w_busy_s) begin
            r_idx   <= c_IDX_TOP;
            r_cnt   <= c_PH_LOAD;
            r_state <= SHIFT;
          end else if (w_cnt_zero) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        SHIFT: begin
          // Data is stable here: the ADC only changes SDOUT after our falling edge.
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end else if (!r_sclk) begin
            r_sclk      <= 1'b1;
            r_sr[r_idx] <= bus.adsdout;
            r_cnt       <= c_PH_LOAD;
          end else begin
            r_sclk <= 1'b0;
            r_cnt  <= c_PH_LOAD;
            if (r_idx == '0) begin
              r_cs    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx - c_IDX_ONE;
            end
          end
        end
        DONE: begin
          r_data   <= r_sr;
          r_dvalid <= 1'b1;
          if (bus.cont) begin
            r_state <= CNV;
            r_cs    <= 1'b0;
            r_cnvst <= 1'b0;
            r_cnt   <= c_CNV_LOAD;
          end else begin
            r_cs    <= 1'b1;
            r_state <= IDLE;
          end
        end
        ERR: begin
          r_timeout <= 1'b1;
          r_cs      <= 1'b1;
          r_cnvst   <= 1'b1;
          r_sclk    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_cs    <= 1'b1;
          r_cnvst <= 1'b1;
          r_sclk  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.adcs    = r_cs;
  assign bus.adcnvst = r_cnvst;
  assign bus.adsclk  = r_sclk;
  assign bus.data    = r_data;
  assign bus.dvalid  = r_dvalid;
  assign bus.timeout = r_timeout;
  assign bus.active  = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_ad7643_serial_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ad7643_serial_reader                                              |
// | Directed bench with a behavioural AD7643 serial-slave model.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ad7643_serial_reader;
  import adc_pkg::*;

  localparam int NB = AD7643_NBITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  ad7643_serial_reader_if #(.NBITS(NB)) bus ();

  ad7643_serial_reader #(
    .NBITS        (NB),
    .DIV          (2),
    .CNV_LOW      (3),
    .BUSY_TIMEOUT (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ADC model: 0 = normal conversion, 1 = BUSY never rises, 2 = BUSY stuck high
  int            m_mode = 0;
  int            m_busy = 40;
  int            m_ptr  = 0;
  logic [NB-1:0] m_cur  = '0;
  logic [NB-1:0] m_q[$];

  int   cyc = 0, n_rises = 0, n_falls = 0, dv_count = 0;
  int   cnv_run = 0, last_cnv_len = 0, hi_run = 0, lo_run = 0;
  int   hi_min, hi_max, lo_min, lo_max, last_fall, min_sp;
  logic seen_fall = 1'b0, p_sclk = 1'b0, p_cnv = 1'b1;
  logic [NB-1:0] dv_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_rises   = 0;
    n_falls   = 0;
    last_fall = -1;
    min_sp    = 1 << 30;
    hi_min    = 1000;
    hi_max    = 0;
    lo_min    = 1000;
    lo_max    = 0;
    dv_q.delete();
  endtask

  initial begin
    forever begin
      @(negedge bus.adcnvst);
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      if (m_mode == 0) begin
        repeat (2) @(posedge clk);
        #1 bus.adbusy = 1'b1;
        repeat (m_busy) @(posedge clk);
        #1;
        m_ptr       = NB - 1;
        bus.adsdout = m_cur[NB-1];
        bus.adbusy  = 1'b0;
      end else if (m_mode == 2) begin
        repeat (2) @(posedge clk);
        #1 bus.adbusy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge bus.adsclk);
      if (m_ptr > 0) begin
        m_ptr--;
        bus.adsdout = m_cur[m_ptr];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.adsclk && !p_sclk) begin
        n_rises++;
        if (seen_fall) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        hi_run = 0;
      end
      if (!bus.adsclk && p_sclk) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        seen_fall = 1'b1;
        lo_run    = 0;
      end
      if (bus.adsclk) hi_run++;
      else            lo_run++;
      if (bus.adcs) seen_fall = 1'b0;
      if (!bus.adcnvst) begin
        if (p_cnv) begin
          n_falls++;
          if (last_fall >= 0 && (cyc - last_fall) < min_sp) min_sp = cyc - last_fall;
          last_fall = cyc;
        end
        cnv_run++;
      end else if (!p_cnv) begin
        last_cnv_len = cnv_run;
        cnv_run      = 0;
      end
      if (bus.dvalid) begin
        dv_count++;
        dv_q.push_back(bus.data);
      end
      p_sclk = bus.adsclk;
      p_cnv  = bus.adcnvst;
    end
  end

  // Called on a falling clock edge; START is sampled by the next rising edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_dv(input int target, input string tag);
    int n;
    n = 0;
    while (dv_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_dv_seen"}, dv_count, target);
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    while (!bus.timeout && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_conv(input logic [NB-1:0] v, input string tag);
    int base;
    base = dv_count;
    m_q.push_back(v);
    pulse_start();
    chk({tag, "_cs_low"},    bus.adcs,    1'b0);
    chk({tag, "_cnvst_low"}, bus.adcnvst, 1'b0);
    chk({tag, "_to_clear"},  bus.timeout, 1'b0);
    wait_dv(base + 1, tag);
    chk({tag, "_data"}, bus.data, v);
  endtask

  initial begin
    int base, n;
    bus.start   = 1'b0;
    bus.cont    = 1'b0;
    bus.adbusy  = 1'b0;
    bus.adsdout = 1'b0;
    clear_mon();

    repeat (3) @(negedge clk);
    chk("rst_cs",      bus.adcs,    1'b1);
    chk("rst_cnvst",   bus.adcnvst, 1'b1);
    chk("rst_sclk",    bus.adsclk,  1'b0);
    chk("rst_data",    bus.data,    18'h0);
    chk("rst_dvalid",  bus.dvalid,  1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_active",  bus.active,  1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single conversion
    clear_mon();
    base = dv_count;
    run_conv(18'h2A5C3, "t1");
    repeat (5) @(negedge clk);
    chk("t1_cnv_len",   last_cnv_len, 3);
    chk("t1_rises",     n_rises,      18);
    chk("t1_dv_pulses", dv_count,     base + 1);
    chk("t1_timeout",   bus.timeout,  1'b0);
    chk("t1_active",    bus.active,   1'b0);
    chk("t1_cs_idle",   bus.adcs,     1'b1);

    // Bit order and extremes, SCLK phase widths
    clear_mon();
    run_conv(18'h20000, "t2a");
    repeat (5) @(negedge clk);
    run_conv(18'h00001, "t2b");
    repeat (5) @(negedge clk);
    run_conv(18'h3FFFF, "t2c");
    repeat (5) @(negedge clk);
    chk("t2_rises",  n_rises, 54);
    chk("t2_hi_min", hi_min,  2);
    chk("t2_hi_max", hi_max,  2);
    chk("t2_lo_min", lo_min,  2);
    chk("t2_lo_max", lo_max,  2);

    // Continuous mode, three conversions, stray STARTs ignored
    clear_mon();
    base = dv_count;
    m_q.push_back(18'd1);
    m_q.push_back(18'd2);
    m_q.push_back(18'd3);
    bus.cont = 1'b1;
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_dv(base + 1, "t3a");
    repeat (10) @(negedge clk);
    pulse_start();
    wait_dv(base + 2, "t3b");
    bus.cont = 1'b0;
    wait_dv(base + 3, "t3c");
    repeat (150) @(negedge clk);
    chk("t3_dv_total", dv_count,    base + 3);
    chk("t3_dv_size",  dv_q.size(), 3);
    chk("t3_dv0",      dv_q[0],     18'd1);
    chk("t3_dv1",      dv_q[1],     18'd2);
    chk("t3_dv2",      dv_q[2],     18'd3);
    chk("t3_falls",    n_falls,     3);
    chk("t3_spacing",  min_sp >= 82, 1'b1);
    chk("t3_active",   bus.active,  1'b0);

    // BUSY never rises
    clear_mon();
    base   = dv_count;
    m_mode = 1;
    pulse_start();
    wait_timeout(n);
    chk("t4_timeout",  bus.timeout, 1'b1);
    chk("t4_latency",  (n >= 256 && n <= 264), 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_no_dv",    dv_count,   base);
    chk("t4_data",     bus.data,   18'd3);
    chk("t4_active",   bus.active, 1'b0);
    chk("t4_cs",       bus.adcs,   1'b1);
    m_mode = 0;
    run_conv(18'h0F0F0, "t4b");

    // BUSY stuck high
    repeat (5) @(negedge clk);
    clear_mon();
    base   = dv_count;
    m_mode = 2;
    pulse_start();
    wait_timeout(n);
    chk("t5_timeout",  bus.timeout, 1'b1);
    chk("t5_latency",  (n >= 257 && n <= 266), 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_no_dv",    dv_count,    base);
    chk("t5_data",     bus.data,    18'h0F0F0);
    chk("t5_sclk",     bus.adsclk,  1'b0);
    chk("t5_active",   bus.active,  1'b0);
    bus.adbusy = 1'b0;
    m_mode     = 0;
    repeat (5) @(negedge clk);
    run_conv(18'h12345, "t5b");

    // Asynchronous reset in the middle of the shift
    repeat (5) @(negedge clk);
    clear_mon();
    m_q.push_back(18'h3C3C3);
    pulse_start();
    n = 0;
    while (n_rises < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_mid_shift", bus.adsclk, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cs",      bus.adcs,    1'b1);
    chk("t6_cnvst",   bus.adcnvst, 1'b1);
    chk("t6_sclk",    bus.adsclk,  1'b0);
    chk("t6_data",    bus.data,    18'h0);
    chk("t6_dvalid",  bus.dvalid,  1'b0);
    chk("t6_timeout", bus.timeout, 1'b0);
    chk("t6_active",  bus.active,  1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    run_conv(18'h15A5A, "t6b");
    repeat (5) @(negedge clk);
    chk("t6b_rises", n_rises, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
